sha_header_streamer: RTL and testbench

SHA_HEADER_STREAMER -- requirements
Module: sha_header_streamer

---
 rtl/sha_header_streamer_if.sv | 26 ++
 rtl/sha_header_streamer.sv | 201 ++++++++++++++++++++
 tb/tb_sha_header_streamer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha_header_streamer_if.sv
// Stream-side bundle between the header streamer and the downstream hash core.
// The streamer drives the message words, the restart pulse and the nonce
// currently in flight; the core returns word_ready.
interface sha_header_streamer_if;
   logic [31:0] word_o;
   logic        word_valid;
   logic        word_ready;
   logic        output_begin;
   logic [31:0] cur_nonce;

   modport master (
      output word_o,
      output word_valid,
      output output_begin,
      output cur_nonce,
      input  word_ready
   );

   modport slave (
      input  word_o,
      input  word_valid,
      input  output_begin,
      input  cur_nonce,
      output word_ready
   );
endinterface

// File: rtl/sha_header_streamer.sv
// Streams padded 80-byte block-header messages (19 header words + nonce +
// SHA-256 padding, 32 words total) to a hash core, one message per nonce.
// A captured header is replayed for nonce_count consecutive nonces, each
// message preceded by a one-cycle begin pulse and followed by an idle gap.
module sha_header_streamer #(
   parameter int GAP_CYCLES = 48
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [607:0]           header,
   input  logic [31:0]            nonce_start,
   input  logic [31:0]            nonce_count,
   output logic                   busy,
   output logic                   done,
   sha_header_streamer_if.master  stream
);

   // The gap counter runs 0..GAP_CYCLES-1 and never needs to hold GAP_CYCLES.
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

   localparam logic [4:0]  LAST_IDX   = 5'd31;
   localparam logic [31:0] PAD_ONE    = 32'h8000_0000;
   localparam logic [31:0] PAD_LENGTH = 32'h0000_0280;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BEGIN  = 2'd1,
      STREAM = 2'd2,
      GAP    = 2'd3
   } state_t;

   state_t             state_reg, state_next;
   logic [607:0]       header_reg, header_next;
   logic [31:0]        remaining_reg, remaining_next;
   logic [31:0]        cur_nonce_reg, cur_nonce_next;
   logic [4:0]         idx_reg, idx_next;
   logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
   logic [31:0]        word_reg, word_next;
   logic               valid_reg, valid_next;
   logic               begin_reg, begin_next;
   logic               busy_reg, busy_next;
   logic               done_reg, done_next;

   logic [31:0]        hdr_words [19];
   logic [4:0]         idx_plus;
   logic [31:0]        upcoming_word;
   logic               accept;
   logic               msg_end;

   // Split the captured header into its 19 words, H0 in the top bits.
   generate
      for (genvar gi = 0; gi < 19; gi++) begin : g_hdr_words
         assign hdr_words[gi] = header_reg[607 - 32*gi -: 32];
      end
   endgenerate

   assign idx_plus = idx_reg + 5'd1;
   assign accept   = valid_reg & stream.word_ready;

   // Message word for the index that follows the current one; word 0 is
   // produced separately when leaving BEGIN.
   always_comb begin
      upcoming_word = 32'h0000_0000;
      if (idx_plus < 5'd19) begin
         upcoming_word = hdr_words[idx_plus];
      end else begin
         case (idx_plus)
            5'd19:   upcoming_word = cur_nonce_reg;
            5'd20:   upcoming_word = PAD_ONE;
            5'd31:   upcoming_word = PAD_LENGTH;
            default: upcoming_word = 32'h0000_0000;
         endcase
      end
   end

   // Next-state and next-output logic; every output is the registered
   // copy of a *_next value so nothing combinational reaches a port.
   always_comb begin
      state_next     = state_reg;
      header_next    = header_reg;
      remaining_next = remaining_reg;
      cur_nonce_next = cur_nonce_reg;
      idx_next       = idx_reg;
      gap_cnt_next   = gap_cnt_reg;
      word_next      = word_reg;
      valid_next     = valid_reg;
      begin_next     = 1'b0;
      busy_next      = busy_reg;
      done_next      = 1'b0;
      msg_end        = 1'b0;

      case (state_reg)
         IDLE: begin
            if (load) begin
               header_next    = header;
               cur_nonce_next = nonce_start;
               remaining_next = nonce_count;
               if (nonce_count != 32'd0) begin
                  busy_next  = 1'b1;
                  begin_next = 1'b1;
                  state_next = BEGIN;
               end else begin
                  // Nothing to stream: report completion straight away.
                  done_next = 1'b1;
                  busy_next = 1'b0;
               end
            end
         end

         BEGIN: begin
            idx_next   = 5'd0;
            word_next  = hdr_words[0];
            valid_next = 1'b1;
            state_next = STREAM;
         end

         STREAM: begin
            if (accept) begin
               if (idx_reg == LAST_IDX) begin
                  valid_next   = 1'b0;
                  word_next    = 32'h0000_0000;
                  gap_cnt_next = '0;
                  if (GAP_CYCLES == 0) begin
                     msg_end = 1'b1;
                  end else begin
                     state_next = GAP;
                  end
               end else begin
                  idx_next  = idx_plus;
                  word_next = upcoming_word;
               end
            end
         end

         GAP: begin
            if (gap_cnt_reg == GAP_LAST) begin
               msg_end = 1'b1;
            end else begin
               gap_cnt_next = gap_cnt_reg + GAP_W'(1);
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      // End of a message (after its gap): either start the next nonce or finish.
      if (msg_end) begin
         remaining_next = remaining_reg - 32'd1;
         if (remaining_reg != 32'd1) begin
            cur_nonce_next = cur_nonce_reg + 32'd1;
            begin_next     = 1'b1;
            state_next     = BEGIN;
         end else begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
         end
      end
   end

   // State and output registers, cleared asynchronously by rst low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         header_reg    <= '0;
         remaining_reg <= '0;
         cur_nonce_reg <= '0;
         idx_reg       <= '0;
         gap_cnt_reg   <= '0;
         word_reg      <= '0;
         valid_reg     <= 1'b0;
         begin_reg     <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         header_reg    <= header_next;
         remaining_reg <= remaining_next;
         cur_nonce_reg <= cur_nonce_next;
         idx_reg       <= idx_next;
         gap_cnt_reg   <= gap_cnt_next;
         word_reg      <= word_next;
         valid_reg     <= valid_next;
         begin_reg     <= begin_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
      end
   end

   assign stream.word_o       = word_reg;
   assign stream.word_valid   = valid_reg;
   assign stream.output_begin = begin_reg;
   assign stream.cur_nonce    = cur_nonce_reg;
   assign busy                = busy_reg;
   assign done                = done_reg;

endmodule

// File: tb/tb_sha_header_streamer.sv
// Scoreboard bench for sha_header_streamer: expected nonces and words are
// queued when a load is driven and popped as begin pulses / accepted words
// appear on the stream interface.
module tb_sha_header_streamer;

   localparam int GAP = 48;
   localparam int PERIOD = 1 + 32 + GAP;

   logic         clk;
   logic         rst;
   logic         load;
   logic [607:0] header;
   logic [31:0]  nonce_start;
   logic [31:0]  nonce_count;
   logic         busy;
   logic         done;

   sha_header_streamer_if sif ();

   sha_header_streamer #(.GAP_CYCLES(GAP)) dut (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .header      (header),
      .nonce_start (nonce_start),
      .nonce_count (nonce_count),
      .busy        (busy),
      .done        (done),
      .stream      (sif.master)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [31:0] exp_word_q[$];
   logic [31:0] exp_nonce_q[$];
   int          begin_cyc_q[$];

   int          begin_cnt = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;
   int          valid_cnt = 0;
   int          accept_cnt = 0;
   int          msg_words = 0;
   int          msg_valid_seen = 0;
   int          first_valid_cyc = 0;
   int          last_word_cyc = 0;
   int          load_cyc = 0;
   logic        held_pending = 1'b0;
   logic [31:0] held_word = '0;
   int          ready_mode = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h want=0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] model_word(input logic [607:0] h, input logic [31:0] n, input int i);
      if (i < 19)  return h[607 - 32*i -: 32];
      if (i == 19) return n;
      if (i == 20) return 32'h8000_0000;
      if (i == 31) return 32'h0000_0280;
      return 32'h0000_0000;
   endfunction

   initial clk = 1'b0;
   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Backstop in case a bounded wait is mis-sized.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Ready generator: steady 1, or the repeating 1,0,0,1 pattern.
   initial begin
      int phase = 0;
      sif.word_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 0) begin
            sif.word_ready = 1'b1;
         end else begin
            sif.word_ready = (phase == 0 || phase == 3);
            phase = (phase + 1) % 4;
         end
      end
   end

   // Monitor: samples on the falling edge, mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         if (sif.output_begin) begin
            begin_cnt++;
            begin_cyc_q.push_back(cyc);
            msg_words = 0;
            msg_valid_seen = 0;
            check_eq("begin_valid_low", {31'd0, sif.word_valid}, 32'd0);
            if (exp_nonce_q.size() == 0)
               check_eq("unexpected_begin", 32'(exp_nonce_q.size()), 32'd1);
            else
               check_eq("begin_nonce", sif.cur_nonce, exp_nonce_q.pop_front());
         end
         if (held_pending) begin
            check_eq("hold_valid", {31'd0, sif.word_valid}, 32'd1);
            check_eq("hold_word", sif.word_o, held_word);
         end
         if (sif.word_valid) begin
            valid_cnt++;
            if (msg_valid_seen == 0) first_valid_cyc = cyc;
            msg_valid_seen++;
         end
         if (sif.word_valid && sif.word_ready) begin
            accept_cnt++;
            last_word_cyc = cyc;
            if (exp_word_q.size() == 0)
               check_eq("unexpected_word", 32'(exp_word_q.size()), 32'd1);
            else
               check_eq($sformatf("word%0d", msg_words), sif.word_o, exp_word_q.pop_front());
            msg_words++;
         end
         held_pending = sif.word_valid && !sif.word_ready;
         held_word    = sif.word_o;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check_eq("done_busy_low", {31'd0, busy}, 32'd0);
         end
      end
   end

   task automatic do_load(input logic [607:0] h, input logic [31:0] start,
                          input logic [31:0] cnt, input bit push);
      @(posedge clk);
      #1;
      load = 1'b1;
      header = h;
      nonce_start = start;
      nonce_count = cnt;
      load_cyc = cyc;
      if (push) begin
         for (int m = 0; m < int'(cnt); m++) begin
            exp_nonce_q.push_back(start + 32'(m));
            for (int i = 0; i < 32; i++)
               exp_word_q.push_back(model_word(h, start + 32'(m), i));
         end
      end
      @(posedge clk);
      #1;
      load = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int start_cnt = done_cnt;
      int n = 0;
      while (done_cnt == start_cnt && n < budget) begin
         @(posedge clk);
         n++;
      end
      check_eq(tag, {31'd0, done_cnt != start_cnt}, 32'd1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_word"},  sif.word_o, 32'd0);
      check_eq({tag, "_valid"}, {31'd0, sif.word_valid}, 32'd0);
      check_eq({tag, "_begin"}, {31'd0, sif.output_begin}, 32'd0);
      check_eq({tag, "_busy"},  {31'd0, busy}, 32'd0);
      check_eq({tag, "_done"},  {31'd0, done}, 32'd0);
      check_eq({tag, "_nonce"}, sif.cur_nonce, 32'd0);
   endtask

   initial begin
      logic [607:0] h;
      int b0, a0, v0, d0;

      rst = 1'b0;
      load = 1'b0;
      header = '0;
      nonce_start = '0;
      nonce_count = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (4) @(negedge clk);
      check_eq("post_reset_busy", {31'd0, busy}, 32'd0);
      $display("txn reset: outputs idle");

      // S1: single message, Hk = 0x01010101*k
      for (int k = 0; k < 19; k++) h[607 - 32*k -: 32] = 32'h0101_0101 * 32'(k);
      begin_cyc_q.delete();
      b0 = begin_cnt; a0 = accept_cnt;
      do_load(h, 32'h10, 32'd1, 1'b1);
      wait_done(PERIOD + 20, "s1_done_timeout");
      check_eq("s1_begin_lat", 32'(begin_cyc_q[0] - load_cyc), 32'd1);
      check_eq("s1_word0_lat", 32'(first_valid_cyc - begin_cyc_q[0]), 32'd1);
      check_eq("s1_done_gap", 32'(done_cyc - last_word_cyc), 32'(GAP + 1));
      check_eq("s1_begins", 32'(begin_cnt - b0), 32'd1);
      check_eq("s1_words", 32'(accept_cnt - a0), 32'd32);
      check_eq("s1_sb_empty", 32'(exp_word_q.size()), 32'd0);
      $display("txn s1: begins=%0d words=%0d done_cycle=%0d", begin_cnt - b0, accept_cnt - a0, done_cyc);

      // S2: three nonces wrapping through 0xFFFFFFFF
      begin_cyc_q.delete();
      b0 = begin_cnt;
      h = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom};
      do_load(h, 32'hFFFF_FFFE, 32'd3, 1'b1);
      wait_done(3 * PERIOD + 20, "s2_done_timeout");
      check_eq("s2_begins", 32'(begin_cnt - b0), 32'd3);
      if (begin_cyc_q.size() == 3) begin
         check_eq("s2_spacing1", 32'(begin_cyc_q[1] - begin_cyc_q[0]), 32'(PERIOD));
         check_eq("s2_spacing2", 32'(begin_cyc_q[2] - begin_cyc_q[1]), 32'(PERIOD));
      end
      check_eq("s2_nonce_q_empty", 32'(exp_nonce_q.size()), 32'd0);
      check_eq("s2_sb_empty", 32'(exp_word_q.size()), 32'd0);
      $display("txn s2: begins=%0d", begin_cnt - b0);

      // S3: ready toggled 1,0,0,1
      ready_mode = 1;
      a0 = accept_cnt;
      h = {19{$urandom}};
      h[607 -: 32] = 32'hDEAD_BEEF;
      do_load(h, 32'h1234_5678, 32'd1, 1'b1);
      wait_done(PERIOD + 4 * 32 + 20, "s3_done_timeout");
      check_eq("s3_words", 32'(accept_cnt - a0), 32'd32);
      check_eq("s3_sb_empty", 32'(exp_word_q.size()), 32'd0);
      ready_mode = 0;
      $display("txn s3: accepted=%0d", accept_cnt - a0);

      // S4: count = 0
      b0 = begin_cnt; v0 = valid_cnt;
      do_load(h, 32'h55, 32'd0, 1'b1);
      wait_done(10, "s4_done_timeout");
      check_eq("s4_done_lat", 32'(done_cyc - load_cyc), 32'd1);
      repeat (10) @(posedge clk);
      check_eq("s4_begins", 32'(begin_cnt - b0), 32'd0);
      check_eq("s4_valids", 32'(valid_cnt - v0), 32'd0);
      $display("txn s4: done_latency=%0d", done_cyc - load_cyc);

      // S5: second load while busy is ignored
      b0 = begin_cnt; d0 = done_cnt;
      do_load(h, 32'h100, 32'd2, 1'b1);
      repeat (15) @(posedge clk);
      do_load(~h, 32'hABC, 32'd5, 1'b0);
      wait_done(2 * PERIOD + 20, "s5_done_timeout");
      repeat (PERIOD + 10) @(posedge clk);
      check_eq("s5_begins", 32'(begin_cnt - b0), 32'd2);
      check_eq("s5_dones", 32'(done_cnt - d0), 32'd1);
      check_eq("s5_nonce_q_empty", 32'(exp_nonce_q.size()), 32'd0);
      check_eq("s5_sb_empty", 32'(exp_word_q.size()), 32'd0);
      $display("txn s5: begins=%0d dones=%0d", begin_cnt - b0, done_cnt - d0);

      // S6: reset at word index 10
      do_load(h, 32'h200, 32'd2, 1'b1);
      begin
         int n = 0;
         while (!(msg_words == 10 && sif.word_valid) && n < 100) begin
            @(negedge clk);
            n++;
         end
         check_eq("s6_reach_idx10", 32'(msg_words), 32'd10);
      end
      #2 rst = 1'b0;
      #1;
      check_idle_outputs("s6_async_reset");
      exp_word_q.delete();
      exp_nonce_q.delete();
      held_pending = 1'b0;
      b0 = begin_cnt; d0 = done_cnt; v0 = valid_cnt;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (3 * PERIOD) @(posedge clk);
      check_eq("s6_no_done", 32'(done_cnt - d0), 32'd0);
      check_eq("s6_no_begin", 32'(begin_cnt - b0), 32'd0);
      check_eq("s6_no_valid", 32'(valid_cnt - v0), 32'd0);
      @(negedge clk);
      check_eq("s6_idle_busy", {31'd0, busy}, 32'd0);
      $display("txn s6: reset mid-stream, idle afterwards");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
